lcd_spi_tx: RTL and testbench
=============================

Name: lcd_spi_tx

Overview:
- Byte-level SPI transmitter for the PCD8544 (Nokia 5110) LCD.
- Sits directly downstream of the display sequencers (configuration and sprite-drawing FSMs). It takes one byte plus a data/command flag per handshake and serialises it MSB-first onto mosi/sclk/sce/dc.
- Also generates the LCD hardware reset pulse after system reset.
- Upstream advances its own step counter on each avail pulse and presents the next byte on the following cycle.

Parameters:
- RST_CYCLES, 16: number of clk cycles rst is held low after reset release before the block accepts bytes.
- DIV_W, 16: width of div_factor.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only in LOAD.
- command  input  1  0 = command byte, 1 = display data; sampled with data_in, drives dc.
- start  input  1  level request; while high, the block keeps accepting bytes.
- div_factor  input  DIV_W  sclk half-period in clk cycles; 0 is treated as 1.
- mosi  output  1  serial data, MSB first.
- sclk  output  1  serial clock; idles low; LCD samples on the rising edge.
- sce  output  1  chip enable, active low.
- dc  output  1  data/command, held stable for the whole byte.
- rst  output  1  LCD reset, active low.
- busy  output  1  high in every state except IDLE.
- avail  output  1  one-cycle pulse: current byte fully shifted, upstream may change data_in/command.

Behaviour:
- Reset values, held while reset is high: mosi=0, sclk=0, sce=1, dc=0, rst=0, busy=1, avail=0; state=RST_LCD; internal counters=0.
- Reset asserted mid-byte aborts the byte immediately: sce goes to 1 and sclk goes to 0 asynchronously. No avail is issued for the aborted byte.
- RST_LCD:
  - rst=0 for RST_CYCLES cycles after reset deasserts, then rst=1 and the block moves to IDLE.
  - rst stays 1 until the next reset.
  - start is ignored in this state; a start still high on reaching IDLE is honoured.
- IDLE: sce=1, sclk=0, busy=0. If start=1, go to LOAD.
- LOAD (1 cycle):
  - shreg<=data_in, dc<=command, sce<=0, bitcnt<=7, divcnt<=0.
  - Next state is SHIFT_LO.
- SHIFT_LO:
  - sclk=0, mosi=shreg[7].
  - After D cycles go to SHIFT_HI, where D = max(div_factor,1). div_factor is re-read each half-period; changing it mid-byte is legal but unspecified for timing.
- SHIFT_HI:
  - sclk=1 for D cycles.
  - Then, if bitcnt==0, go to DONE. Otherwise shreg<=shreg<<1, bitcnt<=bitcnt-1, go to SHIFT_LO.
- DONE (1 cycle):
  - avail=1, sclk=0.
  - sce<=1, unless the optional feature is enabled and start=1.
  - Next state is GAP.
- GAP (1 cycle): gives upstream one cycle to update data_in after avail. Next state is LOAD if start=1, else IDLE.
- Byte period: LOAD to next LOAD is exactly 16*D+3 cycles.
- mosi changes only while sclk=0, so it is stable across every rising edge.
- start falling mid-byte does not truncate the byte. The byte completes, avail still pulses, then the block goes to IDLE.
- start high and reset release in the same cycle: the block enters RST_LCD. The first byte is loaded RST_CYCLES+1 cycles later.
- command is captured only in LOAD; toggling it mid-byte has no effect on dc.

Optional Feature:
- Macro: LCD_SCE_HOLD_EN.
- Defined: sce stays low through DONE/GAP when start=1 at DONE, so back-to-back bytes form one continuous transaction. sce rises only on the DONE that enters IDLE.
- Not defined: sce returns to 1 in DONE after every byte (one-byte frames), and is low again in LOAD.
- Byte period (16*D+3) is identical in both builds.

Test Plan:
- Reset release, RST_CYCLES=16 → rst=0 for exactly 16 cycles, then rst=1. busy=1 until IDLE; sce=1 and sclk=0 throughout.
- D=2, data_in=0x21, command=0, start held → on the 8 sclk rising edges mosi = 0,0,1,0,0,0,0,1. dc=0 and sce=0 during the byte. avail pulses once, 16*2+1 cycles after LOAD.
- Upstream drives 0x21,0x90,0x20,0x0C (command=0), then 0x00 (command=1), changing data on the cycle after each avail → 5 bytes with LOAD spacing 35 cycles. The 5th byte has dc=1. Decoded bytes match in order.
- start dropped in the middle of byte 0xA5 → full 0xA5 shifted, one avail, then IDLE with busy=0 and sce=1. No second LOAD.
- Reset asserted at bit 3 of byte 0xFF → sce=1 and sclk=0 in the same cycle, no avail. The rst pulse sequence restarts on release.
- With LCD_SCE_HOLD_EN, two bytes back-to-back → sce stays low continuously between them. Without the macro → sce=1 for the DONE and GAP cycles between the bytes.

Source files
------------

// File: rtl/lcd_spi_tx.sv
// Byte-wide SPI transmitter for the PCD8544 LCD, including the power-up LCD reset pulse.
// Optional build macro LCD_SCE_HOLD_EN keeps sce low between back-to-back bytes.
module lcd_spi_tx #(
  parameter int RST_CYCLES = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             command,
  input  logic             start,
  input  logic [DIV_W-1:0] div_factor,
  output logic             mosi,
  output logic             sclk,
  output logic             sce,
  output logic             dc,
  output logic             rst,
  output logic             busy,
  output logic             avail
);

  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    RST_LCD  = 3'd0,
    IDLE     = 3'd1,
    LOAD     = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    DONE     = 3'd5,
    GAP      = 3'd6
  } state_t;

  state_t             state_r;
  logic [7:0]         shreg_r;
  logic [2:0]         bitcnt_r;
  logic [DIV_W-1:0]   divcnt_r;
  logic [RCNT_W-1:0]  rcnt_r;
  logic [DIV_W-1:0]   half_s;
  logic               half_end_s;

  // Half-period length with a zero divider clamped to one cycle.
  always_comb begin
    half_s     = DIV_W'(1);
    half_end_s = 1'b0;
    if (div_factor == DIV_W'(0)) begin
      half_s = DIV_W'(1);
    end else begin
      half_s = div_factor;
    end
    // >= so a divider lowered mid-phase still ends the phase
    half_end_s = (divcnt_r >= (half_s - DIV_W'(1)));
  end

  // Sequencer with all outputs registered; reset aborts any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= RST_LCD;
      shreg_r  <= 8'h00;
      bitcnt_r <= 3'd0;
      divcnt_r <= DIV_W'(0);
      rcnt_r   <= RCNT_W'(0);
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      sce      <= 1'b1;
      dc       <= 1'b0;
      rst      <= 1'b0;
      busy     <= 1'b1;
      avail    <= 1'b0;
    end else begin
      case (state_r)
        RST_LCD: begin
          if (rcnt_r == RCNT_W'(RST_CYCLES - 1)) begin
            rst     <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            rcnt_r  <= rcnt_r + RCNT_W'(1);
          end
        end
        IDLE: begin
          sclk <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            sce     <= 1'b0;
            state_r <= LOAD;
          end else begin
            sce     <= 1'b1;
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          shreg_r  <= data_in;
          mosi     <= data_in[7];
          dc       <= command;
          sce      <= 1'b0;
          sclk     <= 1'b0;
          bitcnt_r <= 3'd7;
          divcnt_r <= DIV_W'(0);
          state_r  <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (half_end_s) begin
            divcnt_r <= DIV_W'(0);
            sclk     <= 1'b1;
            state_r  <= SHIFT_HI;
          end else begin
            divcnt_r <= divcnt_r + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (half_end_s) begin
            divcnt_r <= DIV_W'(0);
            sclk     <= 1'b0;
            if (bitcnt_r == 3'd0) begin
              avail   <= 1'b1;
`ifdef LCD_SCE_HOLD_EN
              sce     <= 1'b0;
`else
              sce     <= 1'b1;
`endif
              state_r <= DONE;
            end else begin
              // next bit goes out together with the falling edge
              shreg_r  <= {shreg_r[6:0], 1'b0};
              mosi     <= shreg_r[6];
              bitcnt_r <= bitcnt_r - 3'd1;
              state_r  <= SHIFT_LO;
            end
          end else begin
            divcnt_r <= divcnt_r + DIV_W'(1);
          end
        end
        DONE: begin
          avail <= 1'b0;
          sclk  <= 1'b0;
`ifdef LCD_SCE_HOLD_EN
          if (start) begin
            sce <= 1'b0;
          end else begin
            sce <= 1'b1;
          end
`else
          sce   <= 1'b1;
`endif
          state_r <= GAP;
        end
        GAP: begin
          if (start) begin
            sce     <= 1'b0;
            state_r <= LOAD;
          end else begin
            sce     <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          sclk    <= 1'b0;
          sce     <= 1'b1;
          avail   <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: scoreboard of expected bytes, serial decoder on sclk rising edges.
module tb_lcd_spi_tx;

  localparam int D      = 2;
  localparam int PERIOD = 16 * D + 3;
`ifdef LCD_SCE_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        command;
  logic        start;
  logic [15:0] div_factor;
  logic        mosi, sclk, sce, dc, rst, busy, avail;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [7:0] mon_bits = 8'h00;
  int         mon_n = 0;
  logic       sclk_prev = 1'b0;
  int         avail_cnt = 0;

  lcd_spi_tx dut (
    .clk(clk), .reset(reset), .data_in(data_in), .command(command),
    .start(start), .div_factor(div_factor), .mosi(mosi), .sclk(sclk),
    .sce(sce), .dc(dc), .rst(rst), .busy(busy), .avail(avail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_avail(input string tag);
    int n = 0;
    while (avail !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_avail_timeout"}, {31'd0, avail}, 32'd1);
  endtask

  task automatic count_rst_pulse(input string tag);
    int n = 0;
    while (rst === 1'b0 && n < 100) begin
      tick();
      n++;
      check({tag, "_sce_high"}, {31'd0, sce}, 32'd1);
      check({tag, "_sclk_low"}, {31'd0, sclk}, 32'd0);
      if (rst === 1'b0) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    check({tag, "_rst_low_cycles"}, n, 32'd16);
    check({tag, "_rst_high"}, {31'd0, rst}, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Serial decoder and scoreboard, sampled mid-cycle on the falling clk edge.
  always @(negedge clk) begin
    if (reset) begin
      mon_n     <= 0;
      mon_bits  <= 8'h00;
      sclk_prev <= 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        mon_bits <= {mon_bits[6:0], mosi};
        mon_n    <= mon_n + 1;
        check("sce_low_at_rise", {31'd0, sce}, 32'd0);
      end else if (sclk && sclk_prev) begin
        check("mosi_stable_while_high", {31'd0, mosi}, {31'd0, mon_bits[0]});
      end
      if (avail) begin
        avail_cnt <= avail_cnt + 1;
        check("bits_per_byte", mon_n, 32'd8);
        check("byte_pending", {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          check("byte_value", {24'd0, mon_bits}, {24'd0, exp_q[0][7:0]});
          check("dc_value", {31'd0, dc}, {31'd0, exp_q[0][8]});
          void'(exp_q.pop_front());
        end
        mon_n <= 0;
      end
      sclk_prev <= sclk;
    end
  end

  initial begin
    logic [8:0] stream [5];
    int t_load, t_prev, n, a0, busy_seen;
    stream = '{9'h021, 9'h090, 9'h020, 9'h00C, 9'h100};
    reset = 1'b1; start = 1'b0; data_in = 8'h00; command = 1'b0; div_factor = 16'(D);
    t_load = 0; t_prev = 0;

    repeat (3) tick();
    check("reset_rst", {31'd0, rst}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_sce", {31'd0, sce}, 32'd1);
    check("reset_sclk", {31'd0, sclk}, 32'd0);
    check("reset_avail", {31'd0, avail}, 32'd0);
    check("reset_mosi", {31'd0, mosi}, 32'd0);
    check("reset_dc", {31'd0, dc}, 32'd0);

    @(negedge clk) reset = 1'b0;
    count_rst_pulse("por");

    // Five-byte stream, new data presented the cycle after each avail
    data_in = stream[0][7:0]; command = stream[0][8];
    exp_q.push_back(stream[0]);
    start = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin tick(); n++; end
    t_load = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_avail("stream");
      if (i == 0) check("first_avail_latency", cyc - t_load, 32'(16 * D + 1));
      else        check("byte_period", cyc - t_prev, 32'(PERIOD));
      t_prev = cyc;
      check("sce_in_done", {31'd0, sce}, {31'd0, !HOLD});
      tick();
      check("avail_one_cycle", {31'd0, avail}, 32'd0);
      check("sce_in_gap", {31'd0, sce}, {31'd0, !HOLD});
      if (i < 4) begin
        data_in = stream[i+1][7:0]; command = stream[i+1][8];
        exp_q.push_back(stream[i+1]);
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) tick();
    check("stream_idle_busy", {31'd0, busy}, 32'd0);
    check("stream_idle_sce", {31'd0, sce}, 32'd1);

    // start dropped and command toggled mid-byte
    data_in = 8'hA5; command = 1'b0;
    exp_q.push_back(9'h0A5);
    a0 = avail_cnt;
    start = 1'b1;
    repeat (12) tick();
    start = 1'b0; command = 1'b1; data_in = 8'h5A;
    wait_avail("drop");
    repeat (4) tick();
    check("drop_avail_once", avail_cnt - a0, 32'd1);
    check("drop_idle_busy", {31'd0, busy}, 32'd0);
    check("drop_idle_sce", {31'd0, sce}, 32'd1);
    busy_seen = 0;
    repeat (40) begin tick(); if (busy === 1'b1) busy_seen++; end
    check("drop_no_reload", busy_seen, 32'd0);

    // Reset asserted while bit 3 of 0xFF is on the wire
    data_in = 8'hFF; command = 1'b0;
    a0 = avail_cnt;
    start = 1'b1;
    n = 0;
    while (mon_n < 4 && n < 500) begin tick(); n++; end
    check("abort_reached_bit3", mon_n, 32'd4);
    check("abort_sclk_high", {31'd0, sclk}, 32'd1);
    reset = 1'b1; start = 1'b0;
    #1;
    check("abort_sce_async", {31'd0, sce}, 32'd1);
    check("abort_sclk_async", {31'd0, sclk}, 32'd0);
    check("abort_rst_low", {31'd0, rst}, 32'd0);
    repeat (3) tick();
    check("abort_no_avail", avail_cnt - a0, 32'd0);
    @(negedge clk) reset = 1'b0;
    count_rst_pulse("rerst");
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
